// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU for the RISC-V datapath. Group-0 integer ops complete
// in one cycle; RV32M multiply/divide ops run on a bit-serial engine that
// spends DATA_WIDTH cycles iterating, then one cycle writing the result.
// A valid/ready handshake on both sides lets the pipeline stall around it.
module alu_mdu #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    ALUResult,
   output logic                     Zero
);

   localparam int W  = DATA_WIDTH;
   localparam int SH = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t         state_q;
   logic [SH-1:0]  cnt_q;
   logic [2:0]     mop_q;
   // Shared work register. MUL: {partial product, multiplier}.
   // DIV: {remainder, dividend shifting out / quotient shifting in}.
   logic [2*W-1:0] acc_q;
   // Multiplicand magnitude for MUL, divisor magnitude for DIV.
   logic [W-1:0]   side_q;
   logic [W-1:0]   srcA_q;
   logic           negRes_q;
   logic           negRem_q;
   logic           divZero_q;
   logic           outValid_q;
   logic           zero_q;
   logic [W-1:0]   result_q;

   logic [SH-1:0]  shamt;
   logic [W-1:0]   aluRes_d;
   logic           isMop;
   logic           accept;
   logic           aSigned;
   logic           bSigned;
   logic           signA;
   logic           signB;
   logic [W-1:0]   magA;
   logic [W-1:0]   magB;
   logic [W:0]     mulSum;
   logic [2*W-1:0] mulNext_d;
   logic [W:0]     divShift;
   logic           divFits;
   logic [W-1:0]   divDiff;
   logic [2*W-1:0] divNext_d;
   logic [2*W-1:0] prodFix;
   logic [W-1:0]   quoFix;
   logic [W-1:0]   remFix;
   logic [W-1:0]   mRes_d;

   assign in_ready  = reset && (state_q == S_IDLE) && (!outValid_q || out_ready);
   assign out_valid = outValid_q;
   assign ALUResult = result_q;
   assign Zero      = zero_q;

   assign accept = in_valid && in_ready;
   assign isMop  = Operation[4] && !Operation[3];
   assign shamt  = SrcB[SH-1:0];

   // Single-cycle integer result; 01110/01111 and the 11xxx group yield zero.
   always_comb begin
      aluRes_d = '0;
      if (!Operation[4]) begin
         case (Operation[3:0])
            4'b0000: aluRes_d = SrcA & SrcB;
            4'b0001: aluRes_d = SrcA | SrcB;
            4'b0010: aluRes_d = SrcA + SrcB;
            4'b0011: aluRes_d = SrcA ^ SrcB;
            4'b0100: aluRes_d = SrcA << shamt;
            4'b0101: aluRes_d = SrcA >> shamt;
            4'b0110: aluRes_d[0] = $signed(SrcA) < $signed(SrcB);
            4'b0111: aluRes_d = $unsigned($signed(SrcA) >>> shamt);
            4'b1000: aluRes_d[0] = SrcA == SrcB;
            4'b1001: aluRes_d[0] = SrcA != SrcB;
            4'b1010: aluRes_d = SrcA - SrcB;
            4'b1011: aluRes_d[0] = $signed(SrcA) >= $signed(SrcB);
            4'b1100: aluRes_d[0] = SrcA < SrcB;
            4'b1101: aluRes_d[0] = SrcA >= SrcB;
            default: aluRes_d = '0;
         endcase
      end
   end

   // Operand signedness and magnitudes for an incoming M op; MUL low half is
   // sign-agnostic so it is simply treated as signed*signed.
   always_comb begin
      aSigned = 1'b0;
      bSigned = 1'b0;
      case (Operation[2:0])
         3'b000, 3'b001, 3'b100, 3'b110: begin
            aSigned = 1'b1;
            bSigned = 1'b1;
         end
         3'b010:  aSigned = 1'b1;
         default: begin
            aSigned = 1'b0;
            bSigned = 1'b0;
         end
      endcase
      signA = aSigned && SrcA[W-1];
      signB = bSigned && SrcB[W-1];
      magA  = signA ? -SrcA : SrcA;
      magB  = signB ? -SrcB : SrcB;
   end

   // One shift-add step and one restoring-divide step on the work register.
   always_comb begin
      mulSum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, side_q} : '0);
      mulNext_d = {mulSum, acc_q[W-1:1]};
      divShift  = {acc_q[2*W-1:W], acc_q[W-1]};
      divFits   = divShift >= {1'b0, side_q};
      divDiff   = divShift[W-1:0] - side_q;
      divNext_d = divFits ? {divDiff, acc_q[W-2:0], 1'b1}
                          : {divShift[W-1:0], acc_q[W-2:0], 1'b0};
   end

   // Sign fix-up and special cases applied when the M result is written.
   always_comb begin
      prodFix = negRes_q ? -acc_q : acc_q;
      quoFix  = negRes_q ? -acc_q[W-1:0] : acc_q[W-1:0];
      remFix  = negRem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
      case (mop_q)
         3'b000:         mRes_d = prodFix[W-1:0];
         3'b001, 3'b010,
         3'b011:         mRes_d = prodFix[2*W-1:W];
         3'b100, 3'b101: mRes_d = divZero_q ? '1 : quoFix;
         default:        mRes_d = divZero_q ? srcA_q : remFix;
      endcase
   end

   // Control FSM, iteration datapath and the registered output stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         mop_q      <= '0;
         acc_q      <= '0;
         side_q     <= '0;
         srcA_q     <= '0;
         negRes_q   <= 1'b0;
         negRem_q   <= 1'b0;
         divZero_q  <= 1'b0;
         outValid_q <= 1'b0;
         zero_q     <= 1'b1;
         result_q   <= '0;
      end else begin
         if (outValid_q && out_ready) begin
            outValid_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (isMop) begin
                     mop_q     <= Operation[2:0];
                     srcA_q    <= SrcA;
                     negRes_q  <= signA ^ signB;
                     negRem_q  <= signA;
                     divZero_q <= (SrcB == '0);
                     cnt_q     <= SH'(W - 1);
                     if (Operation[2]) begin
                        acc_q   <= {{W{1'b0}}, magA};
                        side_q  <= magB;
                        state_q <= S_DIV;
                     end else begin
                        acc_q   <= {{W{1'b0}}, magB};
                        side_q  <= magA;
                        state_q <= S_MUL;
                     end
                  end else begin
                     result_q   <= aluRes_d;
                     zero_q     <= (aluRes_d == '0);
                     outValid_q <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               acc_q <= mulNext_d;
               if (cnt_q == '0) begin
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - SH'(1);
               end
            end
            S_DIV: begin
               acc_q <= divNext_d;
               if (cnt_q == '0) begin
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - SH'(1);
               end
            end
            S_DONE: begin
               result_q   <= mRes_d;
               zero_q     <= (mRes_d == '0);
               outValid_q <= 1'b1;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
